// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two per-source result FIFOs merged round-robin onto one registered bus.
// Optional macro CDB_BYPASS_EN lets a result whose FIFO is empty compete for the bus directly.
module cdb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROB_ID_W = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear_flag,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [31:0]         alu_val,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_val,
  output logic                alu_almost_full,
  output logic                lsb_almost_full,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [31:0]         cdb_val,
  output logic                overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ROB_ID_W + 32;
  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [CW-1:0] DepthM1C = CW'(DEPTH - 1);

  // FIFO storage and bookkeeping
  logic [EW-1:0] alu_mem_q [DEPTH];
  logic [EW-1:0] lsb_mem_q [DEPTH];
  logic [PW-1:0] alu_rd_q, alu_rd_d, alu_wr_q, alu_wr_d;
  logic [PW-1:0] lsb_rd_q, lsb_rd_d, lsb_wr_q, lsb_wr_d;
  logic [CW-1:0] alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;

  // Output register and arbitration history
  logic                cdb_valid_q, cdb_valid_d;
  logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [31:0]         cdb_val_q, cdb_val_d;
  logic                last_grant_q, last_grant_d;
  logic                overflow_q, overflow_d;

  logic alu_empty, alu_full, lsb_empty, lsb_full;
  logic alu_byp, lsb_byp, alu_cand, lsb_cand;
  logic grant_alu, grant_lsb;
  logic alu_pop, lsb_pop, alu_push, lsb_push, alu_drop, lsb_drop;
  logic alu_we, lsb_we;
  logic [EW-1:0] alu_in, lsb_in, alu_head, lsb_head, win_entry;

  assign alu_empty = (alu_cnt_q == '0);
  assign lsb_empty = (lsb_cnt_q == '0);
  assign alu_full  = (alu_cnt_q == DepthC);
  assign lsb_full  = (lsb_cnt_q == DepthC);

  assign alu_in   = {alu_rob_id, alu_val};
  assign lsb_in   = {lsb_rob_id, lsb_val};
  assign alu_head = alu_mem_q[alu_rd_q];
  assign lsb_head = lsb_mem_q[lsb_rd_q];

`ifdef CDB_BYPASS_EN
  assign alu_byp = alu_valid && alu_empty;
  assign lsb_byp = lsb_valid && lsb_empty;
`else
  assign alu_byp = 1'b0;
  assign lsb_byp = 1'b0;
`endif

  assign alu_cand = !alu_empty || alu_byp;
  assign lsb_cand = !lsb_empty || lsb_byp;

  // last_grant_q == 1 means the LSB won last, so the ALU takes the next tie
  assign grant_alu = alu_cand && (!lsb_cand || last_grant_q);
  assign grant_lsb = lsb_cand && !grant_alu;

  assign alu_pop = grant_alu && !alu_empty;
  assign lsb_pop = grant_lsb && !lsb_empty;

  // A bypassed winner goes straight to the bus; a full FIFO may still accept if it pops now
  assign alu_push = alu_valid && !(grant_alu && alu_empty) && (!alu_full || alu_pop);
  assign lsb_push = lsb_valid && !(grant_lsb && lsb_empty) && (!lsb_full || lsb_pop);
  assign alu_drop = alu_valid && alu_full && !alu_pop;
  assign lsb_drop = lsb_valid && lsb_full && !lsb_pop;

  always_comb begin
    win_entry = '0;
    if (grant_alu) begin
      win_entry = alu_empty ? alu_in : alu_head;
    end else if (grant_lsb) begin
      win_entry = lsb_empty ? lsb_in : lsb_head;
    end
  end

  assign alu_we = rdy_in && !rst_in && !clear_flag && alu_push;
  assign lsb_we = rdy_in && !rst_in && !clear_flag && lsb_push;

  always_comb begin
    alu_rd_d     = alu_rd_q;
    alu_wr_d     = alu_wr_q;
    alu_cnt_d    = alu_cnt_q;
    lsb_rd_d     = lsb_rd_q;
    lsb_wr_d     = lsb_wr_q;
    lsb_cnt_d    = lsb_cnt_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_val_d    = cdb_val_q;
    last_grant_d = last_grant_q;
    overflow_d   = overflow_q;
    if (rdy_in) begin
      if (clear_flag) begin
        alu_rd_d    = '0;
        alu_wr_d    = '0;
        alu_cnt_d   = '0;
        lsb_rd_d    = '0;
        lsb_wr_d    = '0;
        lsb_cnt_d   = '0;
        cdb_valid_d = 1'b0;
      end else begin
        if (alu_push) alu_wr_d = alu_wr_q + 1'b1;
        if (alu_pop)  alu_rd_d = alu_rd_q + 1'b1;
        case ({alu_push, alu_pop})
          2'b10:   alu_cnt_d = alu_cnt_q + 1'b1;
          2'b01:   alu_cnt_d = alu_cnt_q - 1'b1;
          default: alu_cnt_d = alu_cnt_q;
        endcase

        if (lsb_push) lsb_wr_d = lsb_wr_q + 1'b1;
        if (lsb_pop)  lsb_rd_d = lsb_rd_q + 1'b1;
        case ({lsb_push, lsb_pop})
          2'b10:   lsb_cnt_d = lsb_cnt_q + 1'b1;
          2'b01:   lsb_cnt_d = lsb_cnt_q - 1'b1;
          default: lsb_cnt_d = lsb_cnt_q;
        endcase

        cdb_valid_d = grant_alu || grant_lsb;
        if (grant_alu || grant_lsb) begin
          cdb_rob_id_d = win_entry[EW-1:32];
          cdb_val_d    = win_entry[31:0];
          last_grant_d = grant_lsb;
        end
        if (alu_drop || lsb_drop) overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      alu_rd_q     <= '0;
      alu_wr_q     <= '0;
      alu_cnt_q    <= '0;
      lsb_rd_q     <= '0;
      lsb_wr_q     <= '0;
      lsb_cnt_q    <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_val_q    <= '0;
      last_grant_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      alu_rd_q     <= alu_rd_d;
      alu_wr_q     <= alu_wr_d;
      alu_cnt_q    <= alu_cnt_d;
      lsb_rd_q     <= lsb_rd_d;
      lsb_wr_q     <= lsb_wr_d;
      lsb_cnt_q    <= lsb_cnt_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_val_q    <= cdb_val_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
    end
  end

  // Payload storage needs no reset; the counts decide what is valid
  always_ff @(posedge clk_in) begin
    if (alu_we) alu_mem_q[alu_wr_q] <= alu_in;
    if (lsb_we) lsb_mem_q[lsb_wr_q] <= lsb_in;
  end

  assign alu_almost_full = (alu_cnt_q >= DepthM1C);
  assign lsb_almost_full = (lsb_cnt_q >= DepthM1C);
  assign cdb_valid       = cdb_valid_q;
  assign cdb_rob_id      = cdb_rob_id_q;
  assign cdb_val         = cdb_val_q;
  assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter (DEPTH=4, ROB_ID_W=5, default build without bypass).
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        av, lv;
  logic [4:0]  aid, lid;
  logic [31:0] aval, lval;
  logic        aaf, laf, cv, ovf;
  logic [4:0]  cid;
  logic [31:0] cval;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .DEPTH   (4),
    .ROB_ID_W(5)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .rdy_in         (rdy),
    .clear_flag     (clr),
    .alu_valid      (av),
    .alu_rob_id     (aid),
    .alu_val        (aval),
    .lsb_valid      (lv),
    .lsb_rob_id     (lid),
    .lsb_val        (lval),
    .alu_almost_full(aaf),
    .lsb_almost_full(laf),
    .cdb_valid      (cv),
    .cdb_rob_id     (cid),
    .cdb_val        (cval),
    .overflow_err   (ovf)
  );

  typedef struct packed {
    logic       rst, rdy, clr, av;
    logic [4:0] aid;
    logic       lv;
    logic [4:0] lid;
    logic       cv;
    logic [4:0] eid;
    logic       aaf, laf, ovf;
  } vec_t;

  vec_t vecs[$];

  // Result value carried with each tag; f(0) == 0 so post-reset rows agree
  function automatic logic [31:0] f(input logic [4:0] t);
    return 32'(t) * 32'h0102_0305;
  endfunction

  function automatic vec_t mk(input int r, input int y, input int c, input int a, input int ai,
                              input int l, input int li, input int v, input int ei,
                              input int af, input int lf, input int o);
    vec_t x;
    x.rst = r[0];  x.rdy = y[0];  x.clr = c[0];  x.av = a[0];  x.aid = ai[4:0];
    x.lv  = l[0];  x.lid = li[4:0]; x.cv = v[0]; x.eid = ei[4:0];
    x.aaf = af[0]; x.laf = lf[0]; x.ovf = o[0];
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rdy = 1'b1; clr = 1'b0;
    av = 1'b0; aid = '0; aval = '0;
    lv = 1'b0; lid = '0; lval = '0;
  endtask

  int lat;

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("reset_state", 64'({cv, cid, cval, aaf, laf, ovf}), 64'd0);

    // Single ALU result, measure latency and pulse width
    rst = 1'b0;
    av = 1'b1; aid = 5'd3; aval = 32'h1234_5678;
    tick();
    lat = 1;
    idle_inputs();
    while (!cv && lat < 10) begin
      tick();
      lat++;
    end
`ifdef CDB_BYPASS_EN
    chk("single_latency", 64'(lat), 64'd1);
`else
    chk("single_latency", 64'(lat), 64'd2);
`endif
    chk("single_tag", 64'(cid), 64'd3);
    chk("single_val", 64'(cval), 64'h1234_5678);
    tick();
    chk("single_one_cycle", 64'(cv), 64'd0);

    // rst rdy clr av aid lv lid | cv eid aaf laf ovf
    // Ties: first goes to ALU, then round-robin
    vecs.push_back(mk(1,1,0, 0, 0, 0, 0,  0, 0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1, 1, 1, 2,  0, 0, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 1, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 2, 0,0,0));
    vecs.push_back(mk(0,1,0, 1, 4, 0, 0,  0, 2, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 4, 0,0,0));
    vecs.push_back(mk(0,1,0, 1, 5, 1, 6,  0, 4, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 6, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 5, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  0, 5, 0,0,0));
    // Both sources every cycle: fill, full push+pop, LSB tag 7 dropped
    vecs.push_back(mk(1,1,0, 0, 0, 0, 0,  0, 0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,16, 1, 0,  0, 0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,17, 1, 1,  1,16, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,18, 1, 2,  1, 0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,19, 1, 3,  1,17, 0,1,0));
    vecs.push_back(mk(0,1,0, 1,20, 1, 4,  1, 1, 1,1,0));
    vecs.push_back(mk(0,1,0, 1,21, 1, 5,  1,18, 1,1,0));
    vecs.push_back(mk(0,1,0, 1,22, 1, 6,  1, 2, 1,1,0));
    vecs.push_back(mk(0,1,0, 1,23, 1, 7,  1,19, 1,1,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 3, 1,1,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1,20, 1,1,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 4, 1,0,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1,21, 0,0,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 5, 0,0,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1,22, 0,0,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 6, 0,0,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1,23, 0,0,1));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  0,23, 0,0,1));
    // Reset mid-stream (with rdy low and clear high) wins and clears the sticky flag
    vecs.push_back(mk(0,1,0, 1, 9, 1,10,  0,23, 0,0,1));
    vecs.push_back(mk(0,1,0, 1,11, 1,12,  1,10, 0,0,1));
    vecs.push_back(mk(1,0,1, 1,25, 1,26,  0, 0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,13, 1,14,  0, 0, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1,13, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1,14, 0,0,0));
    // Clear with three entries queued; last_grant (ALU) survives the clear
    vecs.push_back(mk(0,1,0, 1, 8, 1,11,  0,14, 0,0,0));
    vecs.push_back(mk(0,1,0, 1, 9, 1,12,  1, 8, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,10, 1,13,  1,11, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 9, 0,0,0));
    vecs.push_back(mk(0,1,1, 1,14, 1,15,  0, 9, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,20, 1,21,  0, 9, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1,21, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1,20, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  0,20, 0,0,0));
    // Freeze with two entries per FIFO, then four back-to-back broadcasts
    vecs.push_back(mk(0,1,0, 1, 1, 1, 2,  0,20, 0,0,0));
    vecs.push_back(mk(0,1,0, 1, 3, 1, 4,  1, 2, 0,0,0));
    vecs.push_back(mk(0,1,0, 1, 5, 1, 6,  1, 1, 0,0,0));
    vecs.push_back(mk(0,0,0, 1, 7, 1, 8,  1, 1, 0,0,0));
    vecs.push_back(mk(0,0,0, 1, 7, 1, 8,  1, 1, 0,0,0));
    vecs.push_back(mk(0,0,1, 1, 7, 1, 8,  1, 1, 0,0,0));
    vecs.push_back(mk(0,0,0, 1, 7, 1, 8,  1, 1, 0,0,0));
    vecs.push_back(mk(0,0,0, 1, 7, 1, 8,  1, 1, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 4, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 3, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 6, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  1, 5, 0,0,0));
    vecs.push_back(mk(0,1,0, 0, 0, 0, 0,  0, 5, 0,0,0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; rdy = vecs[i].rdy; clr = vecs[i].clr;
      av = vecs[i].av; aid = vecs[i].aid; aval = f(vecs[i].aid);
      lv = vecs[i].lv; lid = vecs[i].lid; lval = f(vecs[i].lid);
      tick();
      chk($sformatf("vec%0d {cv,tag,val,aaf,laf,ovf}", i),
          64'({cv, cid, cval, aaf, laf, ovf}),
          64'({vecs[i].cv, vecs[i].eid, f(vecs[i].eid), vecs[i].aaf, vecs[i].laf, vecs[i].ovf}));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It merges the ALU result stream and the LSB load/store result stream onto one registered broadcast bus that the ROB, RS and LSB all snoop. Each source has a small FIFO so that collisions do not lose results. The block also provides backpressure so the RS and LSB stop producing results before the FIFOs overflow, and it flushes all pending results on a ROB mispredict clear.

## Interface
Parameters:
- `DEPTH`, default 4: entries per source FIFO; power of two, ≥2.
- `ROB_ID_W`, default 5: ROB tag width.

Ports:
- `clk_in` input 1: single clock. All state updates on rising edge.
- `rst_in` input 1: reset, synchronous, active-high.
- `rdy_in` input 1: global enable. When low, all state freezes.
- `clear_flag` input 1: ROB mispredict flush.
- `alu_valid` input 1: ALU result present this cycle.
- `alu_rob_id` input ROB_ID_W: ROB tag of the ALU result.
- `alu_val` input 32: ALU result value.
- `lsb_valid` input 1: LSB result present this cycle.
- `lsb_rob_id` input ROB_ID_W: ROB tag of the LSB result.
- `lsb_val` input 32: LSB result value.
- `alu_almost_full` output 1: RS must not issue to the ALU next cycle.
- `lsb_almost_full` output 1: LSB must not start a new result next cycle.
- `cdb_valid` output 1: broadcast valid (registered).
- `cdb_rob_id` output ROB_ID_W: broadcast tag (registered).
- `cdb_val` output 32: broadcast value (registered).
- `overflow_err` output 1: sticky flag; a push was attempted into a full FIFO.

## Operation
- Two FIFOs, ALU and LSB, each `DEPTH` entries of {rob_id, val}. Each has a read pointer, a write pointer and a count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: the source's `*_valid` is high and its count < DEPTH. If `*_valid` is high while count == DEPTH, the entry is dropped and `overflow_err` is set; it stays set until `rst_in`.
- Arbitration each enabled cycle, over the candidates (FIFO heads, plus bypass inputs when configured):
  - one candidate present → it wins;
  - both present → round-robin against `last_grant`, where 0 = ALU was granted last, 1 = LSB.
  - `last_grant` reset value is 1, so the ALU wins the first tie.
- Winner → output register: `cdb_valid`=1, with the winner's tag and value. Pop the winner's FIFO and update `last_grant`.
- No candidate → `cdb_valid`=0. `cdb_rob_id` and `cdb_val` hold their previous values.
- Same FIFO pushed and popped in the same cycle → count unchanged, both pointers advance. Correct when count==DEPTH: pop and push together are legal, with no overflow.
- `*_almost_full` = (count ≥ DEPTH−1). This is combinational from the count and covers the one result already in flight from the source.
- `clear_flag` high (with `rdy_in` high):
  - both FIFOs are emptied: pointers and count go to 0;
  - that cycle's inputs are discarded;
  - `cdb_valid` goes to 0 at the next edge;
  - `last_grant` and `overflow_err` are kept.
- `rdy_in` low: no push, no pop, outputs held, inputs ignored. `clear_flag` is also ignored.
- Reset: all outputs 0, both FIFOs empty, `last_grant`=1, `overflow_err`=0. Reset mid-stream discards all pending entries. Reset takes priority over `clear_flag` and `rdy_in`.

## Timing
- Without bypass:
  - a result presented in cycle t is written to its FIFO at edge t;
  - the earliest possible broadcast is `cdb_valid` high in cycle t+1 (edge t+1 loads the output register);
  - latency = 2 edges from input.
- With bypass (see Configuration): latency = 1 edge when the source FIFO is empty and the source wins.
- Throughput is one broadcast per cycle. Sustained two-source input drains at one per cycle alternating, and the almost_full flags throttle the sources.
- Result order is preserved within each source. No ordering is defined across sources.

## Configuration
- `CDB_BYPASS_EN` defined:
  - an input whose FIFO is empty competes directly in arbitration that cycle;
  - if it wins, it loads the output register without being pushed;
  - if it loses, it is pushed normally.
- `CDB_BYPASS_EN` undefined:
  - every result passes through its FIFO;
  - arbitration sees FIFO heads only;
  - fixed 2-edge latency.

## Test plan
- Single ALU result, tag 3, val 0x12345678, idle otherwise → `cdb_valid` high exactly one cycle, with tag 3 and that value.
  - Without bypass: 2 edges after input.
  - With bypass: 1 edge after input.
- ALU tag 1 and LSB tag 2 presented in the same cycle after reset → broadcast tag 1 (ALU wins the first tie), then tag 2 the next cycle. A second simultaneous pair (tags 5, 6) → order 6, 5 per round-robin.
- LSB valid every cycle with tags 0..7, DEPTH=4, source ignoring `lsb_almost_full` → `lsb_almost_full` rises when count=3, `overflow_err` sets on the first dropped push, and the broadcast tags are in order with no duplicates.
- Three ALU entries queued, then `clear_flag` for one cycle → `cdb_valid`=0 from the next edge, no queued tag is ever broadcast, and a new result after the clear is broadcast normally.
- `rdy_in` low for 5 cycles while both FIFOs hold 2 entries → outputs and counts frozen. After `rdy_in` returns high, all 4 tags are broadcast over 4 consecutive cycles.
- `rst_in` asserted with both FIFOs non-empty → next cycle all outputs 0 and counts 0. The post-reset tie goes to the ALU.
